adder_sequencer: RTL and testbench

Multi-cycle controller that performs a WIDTH-bit addition by sequencing a single 4-bit adder slice over WIDTH/4 clock cycles, rippling carry between nibbles through a register. It sits between a requester using a simple start/ready/done handshake and the nibble-wide adder datapath, trading latency for area on wide operands.

---
 rtl/adder_seq_pkg.sv | 17 +
 rtl/adder_sequencer_if.sv | 42 ++++
 rtl/adder_sequencer_nibble_adder.sv | 25 ++
 rtl/adder_sequencer.sv | 124 ++++++++++++
 tb/tb_adder_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width for n nibbles; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_sequencer_if.sv
// Requester-side bundle of the adder sequencer.
// Optional subtract port is present only when ADDER_SEQ_SUB_EN is defined.
//
// Handshake: the requester raises start; it is accepted on the first rising
// edge where ready=1, capturing a/b/c_in (and sub). start is ignored while
// ready=0. done pulses for exactly one cycle when sum/c_out/overflow are
// final; they then hold until the next accepted start.
interface adder_sequencer_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADDER_SEQ_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, c_in,
`ifdef ADDER_SEQ_SUB_EN
    output sub,
`endif
    input  ready, sum, c_out, overflow, busy, done
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef ADDER_SEQ_SUB_EN
    input  sub,
`endif
    output ready, sum, c_out, overflow, busy, done
  );

endinterface

// File: rtl/adder_sequencer_nibble_adder.sv
// Combinational 4-bit adder slice; also exposes the carry into its MSB so the
// sequencer can derive signed overflow on the top nibble.
module nibble_adder
  import adder_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] low;
  logic [1:0]          high;

  // Low three bits first; their carry-out is the carry into bit 3.
  assign low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
              + {{(NIBBLE_W-1){1'b0}}, cin};
  assign c3   = low[NIBBLE_W-1];
  assign high = {1'b0, a[NIBBLE_W-1]} + {1'b0, b[NIBBLE_W-1]} + {1'b0, c3};
  assign sum  = {high[0], low[NIBBLE_W-2:0]};
  assign cout = high[1];

endmodule

// File: rtl/adder_sequencer.sv
// WIDTH-bit adder built by sequencing one nibble_adder over WIDTH/4 cycles.
// Define ADDER_SEQ_SUB_EN to add the sub port (a - b via inverted b, carry 1).
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder_sequencer_if.slave         bus,
  output state_t                   dbg_state
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_width_check
    $error("adder_sequencer: WIDTH must be a positive multiple of 4");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             c_out_q;
  logic             ovf_q;

  logic             accept;
  logic             last_nibble;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [NIBBLE_W-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c3;

`ifdef ADDER_SEQ_SUB_EN
  // Subtraction is a + ~b + 1; the caller's c_in is irrelevant then.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1   : bus.c_in;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.c_in;
`endif

  assign accept      = (state_q == IDLE) && bus.start;
  assign last_nibble = (state_q == RUN) && (idx_q == LAST_IDX);

  // Bring the current nibble down to bit 0 for the single shared slice.
  assign a_sh = a_q >> (idx_q * NIBBLE_W);
  assign b_sh = b_q >> (idx_q * NIBBLE_W);

  nibble_adder u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= b_load;
      carry_q <= carry_load;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
      end
      carry_q <= slice_cout;
      if (last_nibble) begin
        c_out_q <= slice_cout;
        ovf_q   <= slice_c3 ^ slice_cout;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (WIDTH=16), add and optional subtract.
module tb_adder_sequencer;
  import adder_seq_pkg::*;

  localparam int W = 16;
  localparam int N = W / 4;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  adder_sequencer_if #(.WIDTH(W)) bus ();

  adder_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {overflow, c_out, sum} from integer arithmetic on the operands.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
    longint ua, ub, sa, sb, r_u, r_s;
    logic   cout, ovf;
    logic [63:0] r_bits;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (longint'(1) << (W-1))) ? ua - (longint'(1) << W) : ua;
    sb = (ub >= (longint'(1) << (W-1))) ? ub - (longint'(1) << W) : ub;
    if (sub) begin
      r_u  = ua - ub;
      cout = (ua >= ub);
      r_s  = sa - sb;
    end else begin
      r_u  = ua + ub + longint'(cin);
      cout = (r_u >= (longint'(1) << W));
      r_s  = sa + sb + longint'(cin);
    end
    ovf    = (r_s > (longint'(1) << (W-1)) - 1) || (r_s < -(longint'(1) << (W-1)));
    r_bits = r_u;
    return {ovf, cout, r_bits[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic set_inputs(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
    bus.a    = a;
    bus.b    = b;
    bus.c_in = cin;
`ifdef ADDER_SEQ_SUB_EN
    bus.sub  = sub;
`endif
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] o_sum,
                       output logic o_cout, output logic o_ovf);
    logic [W+1:0] exp;
    logic [W-1:0] mask;
    int busy_n, done_k;
    bit got;
    o_sum = 'x; o_cout = 1'bx; o_ovf = 1'bx;
    @(negedge clk);
    n_vec++;
    if (bus.ready !== 1'b1) begin
      n_err++; $display("FAIL ready_idle: got %b want 1", bus.ready);
    end
    set_inputs(a, b, cin, sub);
    bus.start = 1'b1;
    exp_q.push_back(ref_result(a, b, cin, sub));
    exp = exp_q[$];
    @(posedge clk);
    #1;
    // Scramble inputs after the accepting edge; the result must not follow them.
    bus.start = 1'b0;
    set_inputs(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    busy_n = 0; done_k = 0; got = 0;
    for (int k = 1; k <= N + 4 && !got; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1; done_k = k;
      end else begin
        if (bus.busy === 1'b1) busy_n++;
        if (k <= N) begin
          mask = W'((longint'(1) << ((k-1)*4)) - 1);
          n_vec++;
          if (bus.sum !== (exp[W-1:0] & mask)) begin
            n_err++;
            $display("FAIL partial_sum k=%0d: got %h want %h", k, bus.sum, exp[W-1:0] & mask);
          end
        end
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", N + 4);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    n_vec += 5;
    if (done_k != N + 1) begin
      n_err++; $display("FAIL done_latency: got %0d want %0d", done_k, N + 1);
    end
    if (busy_n != N) begin
      n_err++; $display("FAIL busy_cycles: got %0d want %0d", busy_n, N);
    end
    if (bus.sum !== exp[W-1:0]) begin
      n_err++; $display("FAIL sum a=%h b=%h cin=%b sub=%b: got %h want %h", a, b, cin, sub, bus.sum, exp[W-1:0]);
    end
    if (bus.c_out !== exp[W]) begin
      n_err++; $display("FAIL c_out a=%h b=%h: got %b want %b", a, b, bus.c_out, exp[W]);
    end
    if (bus.overflow !== exp[W+1]) begin
      n_err++; $display("FAIL overflow a=%h b=%h: got %b want %b", a, b, bus.overflow, exp[W+1]);
    end
    o_sum = bus.sum; o_cout = bus.c_out; o_ovf = bus.overflow;
    @(negedge clk);
    n_vec += 2;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_err++; $display("FAIL done_pulse_end: got done=%b ready=%b want done=0 ready=1", bus.done, bus.ready);
    end
    if (bus.sum !== exp[W-1:0]) begin
      n_err++; $display("FAIL sum_hold: got %h want %h", bus.sum, exp[W-1:0]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    set_inputs('0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #7;
    n_vec += 3;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b want 1 0 0", bus.ready, bus.busy, bus.done);
    end
    if (bus.sum !== '0 || bus.c_out !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_data: got sum=%h c_out=%b ovf=%b want 0", bus.sum, bus.c_out, bus.overflow);
    end
    if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234};
    logic [W-1:0] tb[4] = '{16'h0001, 16'h0000, 16'h0001, 16'h1111};
    logic         tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ts[4] = '{16'h0002, 16'h0000, 16'h8000, 16'h2345};
    logic         tco[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] s; logic co, ov;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b0, s, co, ov);
      n_vec++;
      if (s !== ts[i] || co !== tco[i] || ov !== tov[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got sum=%h c_out=%b ovf=%b want sum=%h c_out=%b ovf=%b",
                 i, s, co, ov, ts[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s; logic co, ov; logic sub;
    for (int i = 0; i < 24; i++) begin
`ifdef ADDER_SEQ_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), sub, s, co, ov);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc = -1;
    int n_acc = 0;
    logic [W+1:0] exp;
    logic [W-1:0] a, b;
    logic cin;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious_done: got done=1 want no pending op");
        end else begin
          exp = exp_q.pop_front();
          if ({bus.overflow, bus.c_out, bus.sum} !== exp) begin
            n_err++; $display("FAIL b2b_result: got %h want %h", {bus.overflow, bus.c_out, bus.sum}, exp);
          end
        end
      end
      if (n_acc < 4) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        set_inputs(a, b, cin, 1'b0);
        bus.start = 1'b1;
        if (bus.ready === 1'b1) begin
          exp_q.push_back(ref_result(a, b, cin, 1'b0));
          if (last_acc >= 0) begin
            n_vec++;
            if (cyc - last_acc != N + 2) begin
              n_err++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, N + 2);
            end
          end
          last_acc = cyc;
          n_acc++;
        end
      end else begin
        bus.start = 1'b0;
      end
      if (n_acc == 4 && exp_q.size() == 0) break;
    end
    bus.start = 1'b0;
    if (n_acc != 4 || exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL b2b_timeout: got %0d accepts, %0d pending, want 4 and 0", n_acc, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic co, ov;
    bit saw_done = 0;
    @(negedge clk);
    set_inputs(16'hABCD, 16'h1357, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.sum === '0) begin
      n_err++; $display("FAIL pre_abort_partial: got %h want nonzero low nibbles", bus.sum);
    end
    rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (bus.sum !== '0 || bus.c_out !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL abort_clear: got sum=%h c_out=%b ovf=%b want 0", bus.sum, bus.c_out, bus.overflow);
    end
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL abort_ctrl: got ready=%b busy=%b done=%b want 1 0 0", bus.ready, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++; $display("FAIL abort_no_done: got done pulse want none");
    end
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, s, co, ov);
    n_vec++;
    if (s !== 16'h2345) begin
      n_err++; $display("FAIL after_abort_sum: got %h want 2345", s);
    end
  endtask

`ifdef ADDER_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s; logic co, ov;
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov);
    n_vec++;
    if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
      n_err++; $display("FAIL sub_5_7: got sum=%h c_out=%b ovf=%b want fffe 0 0", s, co, ov);
    end
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, s, co, ov);
    n_vec++;
    if (s !== 16'h0002 || co !== 1'b1 || ov !== 1'b0) begin
      n_err++; $display("FAIL sub_7_5: got sum=%h c_out=%b ovf=%b want 0002 1 0", s, co, ov);
    end
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov);
    n_vec++;
    if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
      n_err++; $display("FAIL sub_ovf: got sum=%h c_out=%b ovf=%b want 7fff 1 1", s, co, ov);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADDER_SEQ_SUB_EN
    test_sub();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
